// File: rtl/store_write_buffer.sv
// Store write buffer: circular queue of LSU stores, held until the ROB commits
// them and then drained in order to the D-cache or the uncached handler. Also
// produces the per-load dependency mask (rely) and the live-entry mask (cur).
module store_write_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [1:0]       st_size,
    input  logic             st_cache,
    input  logic             commit,
    input  logic [31:0]      ld_addr,
    input  logic             ld_cache,
    output logic [DEPTH-1:0] rely,
    output logic [DEPTH-1:0] cur,
    output logic             da_w,
    input  logic             da_ready,
    output logic [31:0]      da_waddr,
    output logic [31:0]      da_wdata,
    output logic [3:0]       da_wmask,
    output logic             uh_wvalid,
    input  logic             uh_wready,
    output logic [31:0]      uh_waddr,
    output logic [31:0]      uh_wdata,
    output logic [1:0]       uh_wsize,
    output logic [PTR_W:0]   count,
    output logic             empty
);

    typedef enum logic [1:0] {
        s_byte = 2'd0,
        s_half = 2'd1,
        s_word = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CACHED   = 2'd1,
        ST_UNCACHED = 2'd2
    } state_t;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]   head_q, head_d, cmt_q, cmt_d, tail_q, tail_d, cnt_d, head_inc;
    logic [DEPTH-1:0] valid_q, valid_d;
    state_t           state_q, state_d;

    logic [31:0]      mem_addr_q  [DEPTH];
    logic [31:0]      mem_data_q  [DEPTH];
    logic [3:0]       mem_mask_q  [DEPTH];
    logic [1:0]       mem_size_q  [DEPTH];
    logic [DEPTH-1:0] mem_cache_q;

    logic             full, enq, commit_ok, drain_done;
    logic [3:0]       enq_mask;
    logic [PTR_W-1:0] head_idx, tail_idx, next_idx;
    logic             unused_ld_low;

    assign head_idx = head_q[PTR_W-1:0];
    assign tail_idx = tail_q[PTR_W-1:0];
    assign head_inc = head_q + 1'b1;
    assign next_idx = head_inc[PTR_W-1:0];

    assign count    = tail_q - head_q;
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    // A drain finishing this cycle does not free a slot until the next one.
    assign st_ready = ~full & ~flush;
    assign enq      = st_valid & st_ready;
    assign cur      = valid_q;
    assign unused_ld_low = ^ld_addr[1:0];

    // Byte-enable mask for the incoming store.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        enq_mask = 4'hF;
        case (size_e'(st_size))
            s_byte:  enq_mask = 4'b0001 << st_addr[1:0];
            s_half:  enq_mask = 4'b0011 << st_addr[1:0];
            default: enq_mask = 4'hF;
        endcase
    end

    // Pointer updates and the derived live-entry mask.
    always_comb begin
        logic [PTR_W-1:0] off;
        off       = '0;
        commit_ok = commit & (cmt_q != tail_q);
        cmt_d     = cmt_q + {{PTR_W{1'b0}}, commit_ok};
        head_d    = head_q + {{PTR_W{1'b0}}, drain_done};
        // Flush rolls tail back to the commit point; a same-cycle enqueue is lost.
        tail_d    = flush ? cmt_d : tail_q + {{PTR_W{1'b0}}, enq};
        cnt_d     = tail_d - head_d;
        valid_d   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = PTR_W'(i) - head_d[PTR_W-1:0];
            valid_d[i] = ({1'b0, off} < cnt_d);
        end
    end

    // Drain FSM next state; goes straight to the next committed entry when one is ready.
    always_comb begin
        state_d    = state_q;
        drain_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (head_q != cmt_q)
                    state_d = mem_cache_q[head_idx] ? ST_CACHED : ST_UNCACHED;
            end
            ST_CACHED, ST_UNCACHED: begin
                if ((state_q == ST_CACHED) ? da_ready : uh_wready) begin
                    drain_done = 1'b1;
                    if (head_inc != cmt_q)
                        state_d = mem_cache_q[next_idx] ? ST_CACHED : ST_UNCACHED;
                    else
                        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request outputs come from the registered state and the head entry, so they hold until accepted.
    assign da_w      = (state_q == ST_CACHED);
    assign da_waddr  = mem_addr_q[head_idx];
    assign da_wdata  = mem_data_q[head_idx];
    assign da_wmask  = mem_mask_q[head_idx];
    assign uh_wvalid = (state_q == ST_UNCACHED);
    assign uh_waddr  = mem_addr_q[head_idx];
    assign uh_wdata  = mem_data_q[head_idx];
    assign uh_wsize  = mem_size_q[head_idx];

    // Load dependency: same word, or both uncached (keeps uncached accesses ordered).
    always_comb begin
        rely = '0;
        for (int i = 0; i < DEPTH; i++)
            rely[i] = valid_q[i] &
                      ((mem_addr_q[i][31:2] == ld_addr[31:2]) | (~ld_cache & ~mem_cache_q[i]));
    end

    // Control state registers.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            head_q  <= '0;
            cmt_q   <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            state_q <= ST_IDLE;
        end else begin
            head_q  <= head_d;
            cmt_q   <= cmt_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            state_q <= state_d;
        end
    end

    // Entry storage, written at tail on enqueue.
    always_ff @(posedge clk) begin
        // NOTE: the payload array has no reset; valid_q gates every use, so stale contents are harmless.
        if (enq) begin
            mem_addr_q[tail_idx]  <= st_addr;
            mem_data_q[tail_idx]  <= st_data;
            mem_mask_q[tail_idx]  <= enq_mask;
            mem_size_q[tail_idx]  <= st_size;
            mem_cache_q[tail_idx] <= st_cache;
        end
    end

    // Protocol checks: no commit past tail, halfword stores must be aligned.
    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (!(commit && (cmt_q == tail_q)));
            assert (!(enq && (st_size == s_half) && st_addr[0]));
        end
    end

endmodule
